// File: rtl/fabric_cfg_pkg.sv
// Shared constants, field map and FSM state type for the fabric configuration loader.
package fabric_cfg_pkg;

  localparam int unsigned CFG_BITS    = 871;
  localparam int unsigned CFG_BYTES   = (CFG_BITS + 7) / 8;
  localparam int unsigned SHADOW_BITS = CFG_BYTES * 8;
  localparam int unsigned IDX_W       = $clog2(CFG_BYTES);

  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam int unsigned TIMEOUT     = 1024;
  localparam int unsigned TMO_W       = $clog2(TIMEOUT + 1);

  localparam int unsigned BLE_LSB = 0;   localparam int unsigned BLE_W = 9;
  localparam int unsigned IO_LSB  = 9;   localparam int unsigned IO_W  = 4;
  localparam int unsigned LUT_LSB = 13;  localparam int unsigned LUT_W = 144;
  localparam int unsigned SB_LSB  = 157; localparam int unsigned SB_W  = 240;
  localparam int unsigned CB_LSB  = 397; localparam int unsigned CB_W  = 420;
  localparam int unsigned SDB_LSB = 817; localparam int unsigned SDB_W = 36;
  localparam int unsigned SD_LSB  = 853; localparam int unsigned SD_W  = 18;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    COMMIT
  } state_e;

endpackage

// File: rtl/cfg_shadow_reg.sv
// Byte-addressed shadow register collecting the payload, with a running XOR of written bytes.
module cfg_shadow_reg
  import fabric_cfg_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   we_i,
  input  logic [IDX_W-1:0]       idx_i,
  input  logic [7:0]             data_i,
  output logic [SHADOW_BITS-1:0] shadow_o,
  output logic [7:0]             xor_o
);

  logic [SHADOW_BITS-1:0] shadow_q;
  logic [7:0]             xor_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      xor_q    <= '0;
    end else if (clr_i) begin
      xor_q <= '0;
    end else if (we_i) begin
      shadow_q[{idx_i, 3'b000} +: 8] <= data_i;
      xor_q                          <= xor_q ^ data_i;
    end
  end

  assign shadow_o = shadow_q;
  assign xor_o    = xor_q;

endmodule

// File: rtl/fabric_config_loader.sv
// Framed bitstream loader: SYNC, payload into shadow, XOR check, atomic commit to active config.
module fabric_config_loader
  import fabric_cfg_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    cfg_byte,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  output logic [8:0]    BLE_dff_select,
  output logic [3:0]    IO_sel,
  output logic [143:0]  LUT_in,
  output logic [239:0]  SB_in,
  output logic [419:0]  CB_in,
  output logic [35:0]   sel_direction_BLEout,
  output logic [17:0]   sel_direction,
  output logic          fabric_reset,
  output logic          cfg_done,
  output logic          cfg_error
);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic                   frst_q, frst_d;
  logic [CFG_BITS-1:0]    active_q, active_d;
  logic                   sh_clr, sh_we;
  logic [SHADOW_BITS-1:0] shadow;
  logic [7:0]             run_xor;
  logic                   xfer;
  logic                   pad_unused;

  cfg_shadow_reg u_shadow (
    .clk      (clk),
    .rst      (reset),
    .clr_i    (sh_clr),
    .we_i     (sh_we),
    .idx_i    (cnt_q),
    .data_i   (cfg_byte),
    .shadow_o (shadow),
    .xor_o    (run_xor)
  );

  assign pad_unused = shadow[SHADOW_BITS-1];
  assign xfer       = cfg_valid && cfg_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    done_d    = done_q;
    // Held high until the first commit, then only the one-cycle commit pulse.
    frst_d    = done_q ? 1'b0 : frst_q;
    active_d  = active_q;
    cfg_ready = 1'b1;
    sh_clr    = 1'b0;
    sh_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer && cfg_byte == SYNC_BYTE) begin
          sh_clr  = 1'b1;
          cnt_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (xfer) begin
          sh_we = 1'b1;
          tmo_d = '0;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == IDX_W'(CFG_BYTES - 1)) state_d = CHECK;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      CHECK: begin
        if (xfer) begin
          tmo_d = '0;
          if (cfg_byte == run_xor) begin
            state_d = COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      COMMIT: begin
        cfg_ready = 1'b0;
        active_d  = shadow[CFG_BITS-1:0];
        done_d    = 1'b1;
        frst_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      frst_q   <= 1'b1;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      done_q   <= done_d;
      frst_q   <= frst_d;
      active_q <= active_d;
    end
  end

  assign BLE_dff_select       = active_q[BLE_LSB +: BLE_W];
  assign IO_sel               = active_q[IO_LSB  +: IO_W];
  assign LUT_in               = active_q[LUT_LSB +: LUT_W];
  assign SB_in                = active_q[SB_LSB  +: SB_W];
  assign CB_in                = active_q[CB_LSB  +: CB_W];
  assign sel_direction_BLEout = active_q[SDB_LSB +: SDB_W];
  assign sel_direction        = active_q[SD_LSB  +: SD_W];
  assign fabric_reset         = frst_q;
  assign cfg_done             = done_q;
  assign cfg_error            = err_q;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed bench for fabric_config_loader: framing, checksum, timeout, gaps and async reset.
module tb_fabric_config_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   cfg_byte;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [8:0]   BLE_dff_select;
  logic [3:0]   IO_sel;
  logic [143:0] LUT_in;
  logic [239:0] SB_in;
  logic [419:0] CB_in;
  logic [35:0]  sel_direction_BLEout;
  logic [17:0]  sel_direction;
  logic         fabric_reset;
  logic         cfg_done;
  logic         cfg_error;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  fabric_config_loader dut (
    .clk                  (clk),
    .reset                (reset),
    .cfg_byte             (cfg_byte),
    .cfg_valid            (cfg_valid),
    .cfg_ready            (cfg_ready),
    .BLE_dff_select       (BLE_dff_select),
    .IO_sel               (IO_sel),
    .LUT_in               (LUT_in),
    .SB_in                (SB_in),
    .CB_in                (CB_in),
    .sel_direction_BLEout (sel_direction_BLEout),
    .sel_direction        (sel_direction),
    .fabric_reset         (fabric_reset),
    .cfg_done             (cfg_done),
    .cfg_error            (cfg_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [871:0] obs, input logic [871:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame pattern 0: byte k = k; pattern 1: byte k = ~k (k=90 yields 8'hA5 as payload data).
  function automatic logic [7:0] pat(input int sel, input int k);
    logic [7:0] b;
    b = 8'(k);
    return (sel == 1) ? ~b : b;
  endfunction

  function automatic logic [870:0] golden(input int sel);
    logic [871:0] g;
    g = '0;
    for (int k = 0; k < 109; k++) g[8*k +: 8] = pat(sel, k);
    return g[870:0];
  endfunction

  function automatic logic [7:0] csum(input int sel);
    logic [7:0] x;
    x = '0;
    for (int k = 0; k < 109; k++) x = x ^ pat(sel, k);
    return x;
  endfunction

  task automatic send(input logic [7:0] b);
    int w;
    w = 0;
    @(negedge clk);
    while (!cfg_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (w == 8) check("ready_wait", {871'd0, cfg_ready}, 872'd1);
    cfg_byte  = b;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int g);
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (g) @(negedge clk);
  endtask

  // maxgap=0: back-to-back; otherwise random idle gaps plus one 1023-cycle gap at byte 60.
  task automatic send_frame(input int sel, input logic [7:0] corrupt, input int maxgap);
    send(8'hA5);
    for (int k = 0; k < 109; k++) begin
      if (maxgap > 0) gap((k == 60) ? 1022 : int'($urandom_range(0, maxgap)));
      send(pat(sel, k));
    end
    send(csum(sel) ^ corrupt);
  endtask

  task automatic check_cfg(input string tag, input logic [870:0] g);
    check({tag, ".BLE"}, 872'(BLE_dff_select),       872'(g[8:0]));
    check({tag, ".IO"},  872'(IO_sel),               872'(g[12:9]));
    check({tag, ".LUT"}, 872'(LUT_in),               872'(g[156:13]));
    check({tag, ".SB"},  872'(SB_in),                872'(g[396:157]));
    check({tag, ".CB"},  872'(CB_in),                872'(g[816:397]));
    check({tag, ".SDB"}, 872'(sel_direction_BLEout), 872'(g[852:817]));
    check({tag, ".SD"},  872'(sel_direction),        872'(g[870:853]));
  endtask

  task automatic check_flags(input string tag, input logic done, input logic frst, input logic err);
    check({tag, ".done"},  872'(cfg_done),     872'(done));
    check({tag, ".frst"},  872'(fabric_reset), 872'(frst));
    check({tag, ".error"}, 872'(cfg_error),    872'(err));
  endtask

  // Called right after the checksum edge N: old state before N+1, new config with pulse after N+1.
  task automatic expect_commit(input string tag, input int sel, input logic prev_done);
    @(negedge clk);
    cfg_valid = 1'b0;
    check({tag, ".commit_rdy"}, 872'(cfg_ready), 872'd0);
    check({tag, ".pre_done"},   872'(cfg_done),  872'(prev_done));
    check({tag, ".pre_frst"},   872'(fabric_reset), 872'(!prev_done));
    @(negedge clk);
    check_flags({tag, ".n1"}, 1'b1, 1'b1, 1'b0);
    check_cfg(tag, golden(sel));
    @(negedge clk);
    check_flags({tag, ".n2"}, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_byte  = '0;

    @(negedge clk);
    check("rst.ready", 872'(cfg_ready), 872'd1);
    check_flags("rst", 1'b0, 1'b1, 1'b0);
    check_cfg("rst", '0);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back good frame, plus hand-computed field values for pattern 0.
    send_frame(0, 8'h00, 0);
    expect_commit("b2b", 0, 1'b0);
    check("b2b.lut_lo", 872'(LUT_in[7:0]),    872'h10);
    check("b2b.ble",    872'(BLE_dff_select), 872'h100);
    check("b2b.io",     872'(IO_sel),         872'h0);
    check("b2b.sd",     872'(sel_direction),  872'h3635B);

    // Corrupted checksum from reset.
    do_reset();
    send_frame(0, 8'h01, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    check_flags("badck", 1'b0, 1'b1, 1'b1);
    check_cfg("badck", '0);

    // Junk before SYNC is discarded; a good frame clears the error.
    send(8'h00);
    send(8'hFF);
    send(8'h3C);
    send_frame(0, 8'h00, 0);
    expect_commit("lead", 0, 1'b0);

    // Timeout mid-frame keeps config A; boundary at exactly TIMEOUT idle cycles.
    send(8'hA5);
    @(negedge clk);
    check("sync.clr_err", 872'(cfg_error), 872'd0);
    for (int k = 0; k < 49; k++) send(pat(1, k));
    cfg_valid = 1'b0;
    repeat (1024) @(negedge clk);
    check("tmo.edge_1023", 872'(cfg_error), 872'd0);
    @(negedge clk);
    check_flags("tmo", 1'b1, 1'b0, 1'b1);
    check_cfg("tmo", golden(0));
    send_frame(1, 8'h00, 0);
    expect_commit("reloadB", 1, 1'b1);

    // Random gaps up to 1023 idle cycles give the same result as back-to-back.
    send_frame(0, 8'h00, 30);
    expect_commit("gaps", 0, 1'b1);

    // Asynchronous reset between edges mid-LOAD.
    send(8'hA5);
    for (int k = 0; k < 20; k++) send(pat(1, k));
    #2;
    reset = 1'b1;
    #1;
    check("arst.ready", 872'(cfg_ready), 872'd1);
    check_flags("arst", 1'b0, 1'b1, 1'b0);
    check_cfg("arst", '0);
    cfg_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
